burst_ram_arbiter: RTL and testbench
====================================

# burst_ram_arbiter

Two-port arbiter that shares the single burst-RAM command interface of the PSRAM memory controller (`br_*` signals: cmd, cmd_en, addr, wr_data, data_mask, rd_data, rd_data_valid) between two requesters, e.g. the `ramio` cache and a DMA/flash-loader engine. It sits between the requesters and the PSRAM controller in the memory-controller clock domain (`br_clk_out`). It grants whole burst transactions with round-robin fairness and sequences write beats and read-return routing. It enforces a minimum idle gap between commands and times out reads that never complete.

## Interface
- `AddressBitWidth`, 21, burst RAM address width
- `DataBitWidth`, 64, burst beat width; mask width is `DataBitWidth/8`
- `BurstBeatCount`, 4, beats per read or write burst (≥1)
- `CommandGapCycles`, 4, idle cycles after a transaction completes before the next command (0 allowed)
- `ReadTimeoutCycles`, 255, max cycles from command to last read beat (≥BurstBeatCount)
- `clk` in 1: memory-controller clock
- `rst` in 1: asynchronous, active-high reset
- `init_calib` in 1: controller calibrated; no command is issued while 0
- `pN_valid` in 1 (N=0,1): request pending; held with cmd/addr until `pN_ready`
- `pN_cmd` in 1: 0 read, 1 write
- `pN_addr` in AddressBitWidth: burst address
- `pN_wr_data` in DataBitWidth; `pN_data_mask` in DataBitWidth/8: current write beat
- `pN_ready` out 1: one-cycle pulse, request accepted
- `pN_wr_beat` out 1: current `pN_wr_data` consumed this cycle
- `pN_rd_data` out DataBitWidth: `br_rd_data` broadcast to both ports
- `pN_rd_valid` out 1: read beat valid for port N
- `pN_rd_error` out 1: one-cycle pulse, read timed out
- `br_cmd`, `br_cmd_en` out 1; `br_addr` out AddressBitWidth; `br_wr_data` out DataBitWidth; `br_data_mask` out DataBitWidth/8
- `br_rd_data` in DataBitWidth; `br_rd_data_valid` in 1

## Operation
- States: IDLE, WRITE, READ_WAIT, GAP.
- IDLE: if `init_calib`=1 and any `pN_valid`, select a port. If both are valid, select the port not granted last. `last_grant` resets to 1, so port 0 wins first. Register grant, cmd and addr, then enter WRITE or READ_WAIT.
- Cycle after selection (issue cycle): `br_cmd_en`=1, `pN_ready`=1 for granted port only; `br_cmd`/`br_addr` from registers.
- WRITE: beats run from the issue cycle for BurstBeatCount consecutive cycles. `br_wr_data`/`br_data_mask` are a combinational mux of the granted port. `pN_wr_beat`=1 each beat. The requester presents the next beat the cycle after each strobe. After the last beat, go to GAP.
- READ_WAIT: each `br_rd_data_valid` is forwarded to `pN_rd_valid` of the granted port (combinational) and counted. At BurstBeatCount beats, go to GAP.
- Read timeout: a counter starts at the issue cycle. When it reaches ReadTimeoutCycles, pulse `pN_rd_error` and go to GAP. Later stray valid beats are ignored.
- `br_rd_data_valid` outside READ_WAIT is never forwarded.
- GAP: count CommandGapCycles cycles, then go to IDLE. If CommandGapCycles=0, go straight to IDLE.
- `init_calib` falling mid-transaction does not abort it; it only blocks the next selection.
- Outside WRITE, `br_wr_data`/`br_data_mask` are 0 and `pN_wr_beat`=0.

## Timing
- Reset values (asynchronous):
  - state IDLE, all counters 0, `last_grant`=1
  - `br_cmd_en`, `br_cmd`, `br_addr`, `br_wr_data`, `br_data_mask` = 0
  - all `pN_ready`, `pN_wr_beat`, `pN_rd_valid`, `pN_rd_error` = 0
- Reset asserted mid-burst: `br_cmd_en` and strobes drop immediately; the transaction is abandoned.
- Latency: `pN_valid` sampled in IDLE at cycle T → `br_cmd_en`/`pN_ready` at T+1.
- Write beats occupy T+1..T+BurstBeatCount.
- Minimum command-to-command spacing for back-to-back writes: BurstBeatCount+CommandGapCycles+1 cycles.
- `br_cmd_en` is high exactly one cycle per transaction; never two grants in flight.
- Read beats may be non-contiguous; completion counts beats, not cycles.
- A request that drops `pN_valid` before `pN_ready` is a protocol violation; the arbiter still completes the latched transaction.

## Test plan
- Reset, `init_calib`=0, p0_valid=1 write → no `br_cmd_en`. Raise `init_calib` at cycle 10 → `br_cmd_en` and p0_ready at 11; beats 0xA0..0xA3 appear on `br_wr_data` at cycles 11..14.
- p0 read addr 0x000100 → controller returns 4 valid beats with gaps → p0_rd_valid ×4, p1_rd_valid never set; next command not before last beat+CommandGapCycles+1.
- Both ports valid continuously → grants alternate 0,1,0,1; the first grant after reset goes to p0.
- p1 read, controller returns only 2 beats → p1_rd_error pulses exactly at issue+255; state returns to IDLE after GAP; late beats not forwarded.
- Assert `rst` during write beat 2 → all outputs 0 the same cycle; after release, a fresh p1 request issues normally.
- CommandGapCycles=0, p0 back-to-back writes → `br_cmd_en` spacing exactly BurstBeatCount+1 cycles.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares the PSRAM controller burst-RAM command port
// between two requesters. Whole bursts are granted round-robin. Write beats
// are streamed from the granted port, and read beats are routed back to it.
// A fixed idle gap follows every transaction. Reads that never complete are
// ended by a timeout.
//
// Handshake: pN_valid with cmd/addr is held by the requester until pN_ready.
// pN_ready is a one-cycle pulse in the issue cycle, which is the same cycle as
// br_cmd_en. Write data is consumed on every cycle where pN_wr_beat is high.
// The requester presents the next beat in the cycle after each strobe.
module burst_ram_arbiter #(
   parameter int AddressBitWidth   = 21,
   parameter int DataBitWidth      = 64,
   parameter int BurstBeatCount    = 4,
   parameter int CommandGapCycles  = 4,
   parameter int ReadTimeoutCycles = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         init_calib,
   input  logic                         p0_valid,
   input  logic                         p0_cmd,
   input  logic [AddressBitWidth-1:0]   p0_addr,
   input  logic [DataBitWidth-1:0]      p0_wr_data,
   input  logic [DataBitWidth/8-1:0]    p0_data_mask,
   output logic                         p0_ready,
   output logic                         p0_wr_beat,
   output logic [DataBitWidth-1:0]      p0_rd_data,
   output logic                         p0_rd_valid,
   output logic                         p0_rd_error,
   input  logic                         p1_valid,
   input  logic                         p1_cmd,
   input  logic [AddressBitWidth-1:0]   p1_addr,
   input  logic [DataBitWidth-1:0]      p1_wr_data,
   input  logic [DataBitWidth/8-1:0]    p1_data_mask,
   output logic                         p1_ready,
   output logic                         p1_wr_beat,
   output logic [DataBitWidth-1:0]      p1_rd_data,
   output logic                         p1_rd_valid,
   output logic                         p1_rd_error,
   output logic                         br_cmd,
   output logic                         br_cmd_en,
   output logic [AddressBitWidth-1:0]   br_addr,
   output logic [DataBitWidth-1:0]      br_wr_data,
   output logic [DataBitWidth/8-1:0]    br_data_mask,
   input  logic [DataBitWidth-1:0]      br_rd_data,
   input  logic                         br_rd_data_valid,
   output logic [1:0]                   dbg_state_o
);

   localparam int MaskW = DataBitWidth / 8;
   localparam int BeatW = $clog2(BurstBeatCount + 1);
   localparam int ToW   = $clog2(ReadTimeoutCycles + 1);
   localparam int GapW  = (CommandGapCycles > 0) ? $clog2(CommandGapCycles + 1) : 1;

   localparam logic [BeatW-1:0] BeatLast = BeatW'(BurstBeatCount - 1);
   localparam logic [ToW-1:0]   ToLimit  = ToW'(ReadTimeoutCycles);
   localparam logic [GapW-1:0]  GapLast  = GapW'((CommandGapCycles > 0) ? CommandGapCycles - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITE     = 2'd1,
      S_READ_WAIT = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   // With no gap configured, a finished transaction returns straight to IDLE.
   localparam state_t AfterTxn = (CommandGapCycles == 0) ? S_IDLE : S_GAP;

   state_t                 state_q, state_d;
   logic                   grant_q, grant_d;
   logic                   last_grant_q, last_grant_d;
   logic                   cmd_q, cmd_d;
   logic [AddressBitWidth-1:0] addr_q, addr_d;
   logic                   issue_q, issue_d;
   logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
   logic [ToW-1:0]         to_cnt_q, to_cnt_d;
   logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
   logic                   sel;
   logic                   rd_done;

   // Read data is broadcast; only the valid strobe is routed.
   assign p0_rd_data  = br_rd_data;
   assign p1_rd_data  = br_rd_data;
   assign br_cmd      = cmd_q;
   assign br_addr     = addr_q;
   assign dbg_state_o = state_q;

   // State and transaction registers; reset abandons any burst in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cmd_q        <= 1'b0;
         addr_q       <= '0;
         issue_q      <= 1'b0;
         beat_cnt_q   <= '0;
         to_cnt_q     <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         issue_q      <= issue_d;
         beat_cnt_q   <= beat_cnt_d;
         to_cnt_q     <= to_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   // Next-state logic, arbitration, beat sequencing and output strobes.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      issue_d      = 1'b0;
      beat_cnt_d   = beat_cnt_q;
      to_cnt_d     = to_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      sel          = 1'b0;
      rd_done      = 1'b0;
      br_wr_data   = '0;
      br_data_mask = '0;
      p0_wr_beat   = 1'b0;
      p1_wr_beat   = 1'b0;
      p0_rd_valid  = 1'b0;
      p1_rd_valid  = 1'b0;
      p0_rd_error  = 1'b0;
      p1_rd_error  = 1'b0;

      // The issue cycle is the first cycle after selection.
      br_cmd_en = issue_q;
      p0_ready  = issue_q & ~grant_q;
      p1_ready  = issue_q & grant_q;

      case (state_q)
         S_IDLE: begin
            if (init_calib && (p0_valid || p1_valid)) begin
               // On a tie, the port that did not win last time gets the grant.
               sel          = (p0_valid && p1_valid) ? ~last_grant_q : p1_valid;
               grant_d      = sel;
               last_grant_d = sel;
               cmd_d        = sel ? p1_cmd : p0_cmd;
               addr_d       = sel ? p1_addr : p0_addr;
               issue_d      = 1'b1;
               beat_cnt_d   = '0;
               to_cnt_d     = '0;
               gap_cnt_d    = '0;
               state_d      = cmd_d ? S_WRITE : S_READ_WAIT;
            end
         end
         S_WRITE: begin
            br_wr_data   = grant_q ? p1_wr_data : p0_wr_data;
            br_data_mask = grant_q ? p1_data_mask : p0_data_mask;
            p0_wr_beat   = ~grant_q;
            p1_wr_beat   = grant_q;
            beat_cnt_d   = beat_cnt_q + BeatW'(1);
            if (beat_cnt_q == BeatLast) begin
               state_d = AfterTxn;
            end
         end
         S_READ_WAIT: begin
            to_cnt_d = to_cnt_q + ToW'(1);
            if (br_rd_data_valid) begin
               p0_rd_valid = ~grant_q;
               p1_rd_valid = grant_q;
               beat_cnt_d  = beat_cnt_q + BeatW'(1);
               if (beat_cnt_q == BeatLast) begin
                  rd_done = 1'b1;
               end
            end
            // A burst that completes in the timeout cycle is not an error.
            if (!rd_done && (to_cnt_q == ToLimit)) begin
               p0_rd_error = ~grant_q;
               p1_rd_error = grant_q;
               rd_done     = 1'b1;
            end
            if (rd_done) begin
               state_d = AfterTxn;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
            if (gap_cnt_q == GapLast) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter. The stimulus pushes the expected
// commands, beats and errors, each with its cycle number. A negedge monitor
// pops and compares these whenever the DUT strobes. A second instance with no
// command gap checks the spacing between back-to-back writes.
module tb_burst_ram_arbiter;

  localparam int BEATS = 4;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_WRITE = 2'd1, ST_RW = 2'd2, ST_GAP = 2'd3;

  logic clk, rst, init_calib;
  logic p0_valid, p0_cmd, p1_valid, p1_cmd;
  logic [20:0] p0_addr, p1_addr, br_addr;
  logic [63:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data, br_wr_data, br_rd_data;
  logic [7:0] p0_data_mask, p1_data_mask, br_data_mask;
  logic p0_ready, p0_wr_beat, p0_rd_valid, p0_rd_error;
  logic p1_ready, p1_wr_beat, p1_rd_valid, p1_rd_error;
  logic br_cmd, br_cmd_en, br_rd_data_valid;
  logic [1:0] dbg_state;

  // zero-gap instance
  logic g0_rst, g0_valid;
  logic g0_p0_ready, g0_p0_wr_beat, g0_p0_rd_valid, g0_p0_rd_error;
  logic g0_p1_ready, g0_p1_wr_beat, g0_p1_rd_valid, g0_p1_rd_error;
  logic [63:0] g0_p0_rd_data, g0_p1_rd_data, g0_br_wr_data;
  logic [7:0] g0_br_data_mask;
  logic [20:0] g0_br_addr;
  logic g0_br_cmd, g0_br_cmd_en;
  logic [1:0] g0_dbg_state;

  burst_ram_arbiter u_dut (
    .clk(clk), .rst(rst), .init_calib(init_calib),
    .p0_valid(p0_valid), .p0_cmd(p0_cmd), .p0_addr(p0_addr),
    .p0_wr_data(p0_wr_data), .p0_data_mask(p0_data_mask),
    .p0_ready(p0_ready), .p0_wr_beat(p0_wr_beat), .p0_rd_data(p0_rd_data),
    .p0_rd_valid(p0_rd_valid), .p0_rd_error(p0_rd_error),
    .p1_valid(p1_valid), .p1_cmd(p1_cmd), .p1_addr(p1_addr),
    .p1_wr_data(p1_wr_data), .p1_data_mask(p1_data_mask),
    .p1_ready(p1_ready), .p1_wr_beat(p1_wr_beat), .p1_rd_data(p1_rd_data),
    .p1_rd_valid(p1_rd_valid), .p1_rd_error(p1_rd_error),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
    .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
    .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
    .dbg_state_o(dbg_state)
  );

  burst_ram_arbiter #(.CommandGapCycles(0)) u_dut_g0 (
    .clk(clk), .rst(g0_rst), .init_calib(1'b1),
    .p0_valid(g0_valid), .p0_cmd(1'b1), .p0_addr(21'h000040),
    .p0_wr_data(64'h5555), .p0_data_mask(8'hFF),
    .p0_ready(g0_p0_ready), .p0_wr_beat(g0_p0_wr_beat), .p0_rd_data(g0_p0_rd_data),
    .p0_rd_valid(g0_p0_rd_valid), .p0_rd_error(g0_p0_rd_error),
    .p1_valid(1'b0), .p1_cmd(1'b0), .p1_addr(21'h0),
    .p1_wr_data(64'h0), .p1_data_mask(8'h0),
    .p1_ready(g0_p1_ready), .p1_wr_beat(g0_p1_wr_beat), .p1_rd_data(g0_p1_rd_data),
    .p1_rd_valid(g0_p1_rd_valid), .p1_rd_error(g0_p1_rd_error),
    .br_cmd(g0_br_cmd), .br_cmd_en(g0_br_cmd_en), .br_addr(g0_br_addr),
    .br_wr_data(g0_br_wr_data), .br_data_mask(g0_br_data_mask),
    .br_rd_data(64'h0), .br_rd_data_valid(1'b0),
    .dbg_state_o(g0_dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard queues ----------------
  logic [54:0]  exp_cmd_q[$];   // {cyc, port, cmd, addr}
  logic [104:0] exp_wr_q[$];    // {cyc, port, data, mask}
  logic [96:0]  exp_rd_q[$];    // {cyc, port, data}
  logic [32:0]  exp_err_q[$];   // {cyc, port}
  logic [33:0]  exp_state_q[$]; // {cyc, state}
  int           exp_zero_q[$];  // cycles where every strobe must be 0
  logic [95:0]  rd_sched_q[$];  // {cyc, data} controller return beats

  int total, bad;
  logic done, final_done;

  // ---------------- requester model ----------------
  typedef struct packed { logic cmd; logic [20:0] addr; logic [63:0] base; } req_t;
  req_t req0_q[$], req1_q[$];
  req_t h0, h1;
  logic w0_act, w1_act;
  logic [63:0] w0_base, w1_base, d0, d1;
  int w0_idx, w1_idx;
  logic s_r0, s_b0, s_r1, s_b1;

  task automatic drive();
    p0_valid = (req0_q.size() > 0);
    p0_cmd   = p0_valid ? req0_q[0].cmd : 1'b0;
    p0_addr  = p0_valid ? req0_q[0].addr : 21'h0;
    d0 = w0_act ? (w0_base + 64'(w0_idx)) : (p0_valid ? req0_q[0].base : 64'h0);
    p0_wr_data = d0;
    p0_data_mask = ~d0[7:0];
    p1_valid = (req1_q.size() > 0);
    p1_cmd   = p1_valid ? req1_q[0].cmd : 1'b0;
    p1_addr  = p1_valid ? req1_q[0].addr : 21'h0;
    d1 = w1_act ? (w1_base + 64'(w1_idx)) : (p1_valid ? req1_q[0].base : 64'h0);
    p1_wr_data = d1;
    p1_data_mask = ~d1[7:0];
  endtask

  // One clock: sample handshakes at negedge, update drives #1 after posedge.
  task automatic step();
    @(negedge clk);
    s_r0 = p0_ready; s_b0 = p0_wr_beat;
    s_r1 = p1_ready; s_b1 = p1_wr_beat;
    @(posedge clk);
    #1;
    if (s_r0 && req0_q.size() > 0) begin
      h0 = req0_q.pop_front();
      if (h0.cmd) begin w0_act = 1'b1; w0_base = h0.base; w0_idx = 0; end
    end
    if (s_b0) w0_idx++;
    if (w0_idx >= BEATS) begin w0_act = 1'b0; w0_idx = 0; end
    if (s_r1 && req1_q.size() > 0) begin
      h1 = req1_q.pop_front();
      if (h1.cmd) begin w1_act = 1'b1; w1_base = h1.base; w1_idx = 0; end
    end
    if (s_b1) w1_idx++;
    if (w1_idx >= BEATS) begin w1_act = 1'b0; w1_idx = 0; end
    br_rd_data_valid = 1'b0;
    br_rd_data = 64'h0;
    if (rd_sched_q.size() > 0 && int'(rd_sched_q[0][95:64]) == cyc) begin
      br_rd_data_valid = 1'b1;
      br_rd_data = rd_sched_q[0][63:0];
      void'(rd_sched_q.pop_front());
    end
    drive();
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_req(input logic port, input logic cmd, input logic [20:0] addr, input logic [63:0] base);
    req_t r;
    r.cmd = cmd; r.addr = addr; r.base = base;
    if (port) req1_q.push_back(r); else req0_q.push_back(r);
  endtask

  task automatic exp_write(input logic port, input logic [20:0] addr, input logic [63:0] base, input int c, input int nb);
    logic [63:0] d;
    exp_cmd_q.push_back({32'(c), port, 1'b1, addr});
    for (int i = 0; i < nb; i++) begin
      d = base + 64'(i);
      exp_wr_q.push_back({32'(c + i), port, d, ~d[7:0]});
    end
  endtask

  task automatic exp_read(input logic port, input logic [20:0] addr, input int c);
    exp_cmd_q.push_back({32'(c), port, 1'b0, addr});
  endtask

  task automatic sched_beat(input int c, input logic [63:0] data, input logic fwd, input logic port);
    rd_sched_q.push_back({32'(c), data});
    if (fwd) exp_rd_q.push_back({32'(c), port, data});
  endtask

  task automatic exp_state(input int c, input logic [1:0] st);
    exp_state_q.push_back({32'(c), st});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; g0_rst = 1'b1; g0_valid = 1'b0; init_calib = 1'b0;
    br_rd_data_valid = 1'b0; br_rd_data = 64'h0;
    w0_act = 1'b0; w1_act = 1'b0; w0_idx = 0; w1_idx = 0; w0_base = 0; w1_base = 0;
    done = 1'b0;
    drive();
    exp_zero_q.push_back(1);
    exp_state(1, ST_IDLE);

    // Test 1: write held off by init_calib, then issued at cycle 11.
    goto(2);
    rst = 1'b0; g0_rst = 1'b0;
    goto(3);
    push_req(1'b0, 1'b1, 21'h000010, 64'hA0);
    drive();
    exp_write(1'b0, 21'h000010, 64'hA0, 11, BEATS);
    exp_state(10, ST_IDLE); exp_state(12, ST_WRITE);
    exp_state(15, ST_GAP); exp_state(19, ST_IDLE);
    goto(5);
    g0_valid = 1'b1;
    goto(10);
    init_calib = 1'b1;

    // Test 2: p0 read with gapped beats; p1 write waits out the gap.
    goto(20);
    push_req(1'b0, 1'b0, 21'h000100, 64'h0);
    drive();
    exp_read(1'b0, 21'h000100, 21);
    sched_beat(24, 64'h1111_2222_3333_0000, 1'b1, 1'b0);
    sched_beat(26, 64'h1111_2222_3333_0001, 1'b1, 1'b0);
    sched_beat(27, 64'h1111_2222_3333_0002, 1'b1, 1'b0);
    sched_beat(30, 64'h1111_2222_3333_0003, 1'b1, 1'b0);
    exp_state(21, ST_RW); exp_state(31, ST_GAP);
    exp_state(35, ST_IDLE); exp_state(36, ST_WRITE);
    goto(22);
    push_req(1'b1, 1'b1, 21'h000200, 64'hB0);
    drive();
    exp_write(1'b1, 21'h000200, 64'hB0, 36, BEATS);
    goto(40);
    g0_valid = 1'b0;

    // Test 3: both ports busy, grants alternate 0,1,0,1.
    goto(45);
    push_req(1'b0, 1'b1, 21'h000300, 64'hC0);
    push_req(1'b0, 1'b1, 21'h000310, 64'hD0);
    push_req(1'b1, 1'b1, 21'h000400, 64'hE0);
    push_req(1'b1, 1'b1, 21'h000410, 64'hF0);
    drive();
    exp_write(1'b0, 21'h000300, 64'hC0, 46, BEATS);
    exp_write(1'b1, 21'h000400, 64'hE0, 55, BEATS);
    exp_write(1'b0, 21'h000310, 64'hD0, 64, BEATS);
    exp_write(1'b1, 21'h000410, 64'hF0, 73, BEATS);
    exp_state(54, ST_IDLE); exp_state(81, ST_IDLE);

    // Test 4: p1 read gets two beats only, times out at issue+255.
    goto(82);
    push_req(1'b1, 1'b0, 21'h0ABCDE, 64'h0);
    drive();
    exp_read(1'b1, 21'h0ABCDE, 83);
    sched_beat(85, 64'h7777_0000_0000_0000, 1'b1, 1'b1);
    sched_beat(88, 64'h7777_0000_0000_0001, 1'b1, 1'b1);
    sched_beat(340, 64'h7777_0000_0000_0002, 1'b0, 1'b1);
    sched_beat(345, 64'h7777_0000_0000_0003, 1'b0, 1'b1);
    exp_err_q.push_back({32'(338), 1'b1});
    exp_state(337, ST_RW); exp_state(338, ST_RW);
    exp_state(339, ST_GAP); exp_state(343, ST_IDLE);

    // Test 5: reset during write beat 2, then fresh requests.
    goto(350);
    push_req(1'b0, 1'b1, 21'h000500, 64'h50);
    drive();
    exp_write(1'b0, 21'h000500, 64'h50, 351, 2);
    exp_zero_q.push_back(353); exp_zero_q.push_back(354);
    exp_state(353, ST_IDLE);
    goto(353);
    rst = 1'b1;
    req0_q.delete(); req1_q.delete();
    w0_act = 1'b0; w0_idx = 0; w1_act = 1'b0; w1_idx = 0;
    drive();
    goto(355);
    rst = 1'b0;
    goto(356);
    push_req(1'b0, 1'b1, 21'h000600, 64'h60);
    push_req(1'b1, 1'b0, 21'h001234, 64'h0);
    drive();
    exp_write(1'b0, 21'h000600, 64'h60, 357, BEATS);
    exp_read(1'b1, 21'h001234, 366);
    for (int i = 0; i < BEATS; i++)
      sched_beat(368 + i, 64'hDEAD_BEEF_0000_0000 + 64'(i), 1'b1, 1'b1);
    exp_state(357, ST_WRITE); exp_state(366, ST_RW); exp_state(376, ST_IDLE);

    goto(385);
    done = 1'b1;
    repeat (3) @(negedge clk);
    if (!final_done) $display("FAIL final_checks: got not_run want run");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  logic [54:0] ec;
  logic [104:0] ew;
  logic [96:0] er;
  logic [32:0] ee;
  logic [33:0] es;
  int g0_last, g0_cmds;

  initial begin
    total = 0; bad = 0; final_done = 1'b0; g0_last = 0; g0_cmds = 0;
  end

  always @(negedge clk) begin
    // command issue and ready pulse
    if (br_cmd_en) begin
      if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
      else begin
        ec = exp_cmd_q.pop_front();
        chk("cmd_cycle", cyc, ec[54:23]);
        chk("cmd_kind", br_cmd, ec[21]);
        chk("cmd_addr", br_addr, ec[20:0]);
        chk("cmd_ready", {p1_ready, p0_ready}, ec[22] ? 2'd2 : 2'd1);
      end
    end else if (p0_ready || p1_ready) chk("ready_without_cmd", {p1_ready, p0_ready}, 0);

    // write beats
    if (p0_wr_beat || p1_wr_beat) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        ew = exp_wr_q.pop_front();
        chk("wr_cycle", cyc, ew[104:73]);
        chk("wr_port", {p1_wr_beat, p0_wr_beat}, ew[72] ? 2'd2 : 2'd1);
        chk("wr_data", br_wr_data, ew[71:8]);
        chk("wr_mask", br_data_mask, ew[7:0]);
      end
    end else chk("wr_idle_zero", {br_wr_data, br_data_mask}, 0);

    // read beats
    if (p0_rd_valid || p1_rd_valid) begin
      if (exp_rd_q.size() == 0) chk("rd_unexpected", {p1_rd_valid, p0_rd_valid}, 0);
      else begin
        er = exp_rd_q.pop_front();
        chk("rd_cycle", cyc, er[96:65]);
        chk("rd_port", {p1_rd_valid, p0_rd_valid}, er[64] ? 2'd2 : 2'd1);
        chk("rd_data_p0", p0_rd_data, er[63:0]);
        chk("rd_data_p1", p1_rd_data, er[63:0]);
      end
    end

    // read timeout
    if (p0_rd_error || p1_rd_error) begin
      if (exp_err_q.size() == 0) chk("err_unexpected", {p1_rd_error, p0_rd_error}, 0);
      else begin
        ee = exp_err_q.pop_front();
        chk("err_cycle", cyc, ee[32:1]);
        chk("err_port", {p1_rd_error, p0_rd_error}, ee[0] ? 2'd2 : 2'd1);
      end
    end

    // state probes
    if (exp_state_q.size() > 0 && int'(exp_state_q[0][33:2]) == cyc) begin
      es = exp_state_q.pop_front();
      chk("state", dbg_state, es[1:0]);
    end

    // all strobes low while in reset
    if (exp_zero_q.size() > 0 && exp_zero_q[0] == cyc) begin
      void'(exp_zero_q.pop_front());
      chk("reset_zero", {br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask,
                         p0_ready, p0_wr_beat, p0_rd_valid, p0_rd_error,
                         p1_ready, p1_wr_beat, p1_rd_valid, p1_rd_error}, 0);
    end

    // zero-gap instance: back-to-back write spacing is BEATS+1
    if (g0_br_cmd_en) begin
      if (g0_last != 0) chk("g0_spacing", cyc - g0_last, BEATS + 1);
      g0_last = cyc;
      g0_cmds++;
    end

    if (done && !final_done) begin
      chk("cmd_q_left", exp_cmd_q.size(), 0);
      chk("wr_q_left", exp_wr_q.size(), 0);
      chk("rd_q_left", exp_rd_q.size(), 0);
      chk("err_q_left", exp_err_q.size(), 0);
      chk("state_q_left", exp_state_q.size(), 0);
      chk("g0_cmd_count", g0_cmds, 7);
      final_done = 1'b1;
    end
  end

endmodule
